// File: rtl/activate_mid.sv
// Hard-sigmoid activation stage, y = clamp(0.25*x + 0.5, 0, 1), FP32, one sample per clock.
// Also contains the pipelined FP32 adder used for the +0.5 term.

module fp_add_sub #(
  parameter int LAT = 7
) (
  input  logic        clock,
  input  logic        add_sub,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  output logic [31:0] result
);
  logic               swap, sx, sy, rnd;
  logic [7:0]         ex, ey, d;
  logic [23:0]        hx, hy;
  logic [71:0]        smallExt, jam;
  logic [72:0]        sum, norm;
  logic [6:0]         p;
  logic signed [9:0]  expN;
  logic [24:0]        mant;
  logic [31:0]        res;
  logic [LAT-1:0][31:0] pipe;

  // Round-to-nearest-even; denormal inputs and underflowing results flush to zero.
  always_comb begin
    swap     = datab[30:0] > dataa[30:0];
    sx       = swap ? (datab[31] ^ ~add_sub) : dataa[31];
    sy       = swap ? dataa[31] : (datab[31] ^ ~add_sub);
    ex       = swap ? datab[30:23] : dataa[30:23];
    ey       = swap ? dataa[30:23] : datab[30:23];
    hx       = (ex == 8'd0) ? 24'd0 : {1'b1, swap ? datab[22:0] : dataa[22:0]};
    hy       = (ey == 8'd0) ? 24'd0 : {1'b1, swap ? dataa[22:0] : datab[22:0]};
    d        = ex - ey;
    smallExt = {hy, 48'd0};
    // bits shifted past the 48 guard positions are jammed into the LSB as sticky
    jam      = (d >= 8'd72) ? 72'(|hy)
                            : (smallExt >> d) | 72'(|(smallExt << (8'd72 - d)));
    sum      = (sx == sy) ? {1'b0, hx, 48'd0} + {1'b0, jam}
                          : {1'b0, hx, 48'd0} - {1'b0, jam};
    p = 7'd0;
    for (int i = 0; i < 73; i++)
      if (sum[i]) p = 7'(i);
    norm = sum << (7'd72 - p);
    rnd  = norm[48] & ((|norm[47:0]) | norm[49]);
    mant = {1'b0, norm[72:49]} + 25'(rnd);
    expN = $signed({2'b00, ex}) + $signed({3'b000, p}) - 10'sd71 + (mant[24] ? 10'sd1 : 10'sd0);
    if (sum == 73'd0)          res = 32'd0;
    else if (expN <= 10'sd0)   res = {sx, 31'd0};
    else if (expN >= 10'sd255) res = {sx, 8'hFF, 23'd0};
    else                       res = {sx, expN[7:0], mant[22:0]};
  end

  always_ff @(posedge clock) begin
    pipe[0] <= res;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end

  assign result = pipe[LAT-1];
endmodule

module activate_mid #(
  parameter int ADD_LAT = 7,
  parameter int CNT_W   = 16
) (
  input  logic             iCLK,
  input  logic             iRST_N,
  input  logic             iVALID,
  input  logic [31:0]      iSUM,
  output logic             oVALID,
  output logic [31:0]      oACT,
  output logic             oBIT,
  output logic [CNT_W-1:0] oCOUNT
);
  localparam logic [1:0] CLS_LIN  = 2'd0;
  localparam logic [1:0] CLS_SAT0 = 2'd1;
  localparam logic [1:0] CLS_SAT1 = 2'd2;
  localparam logic [1:0] CLS_NAN  = 2'd3;

  logic                  s;
  logic [7:0]            e;
  logic [22:0]           m;
  logic [1:0]            cls;
  logic [31:0]           scaled, s0Scaled, addRes, actN;
  logic                  bitN;
  logic [ADD_LAT:0]      vldPipe;
  logic [ADD_LAT:0][1:0] clsPipe;

  assign {s, e, m} = iSUM;

  // |x| < 2 here, so 0.25*x is an exponent decrement; tiny values become +0 -> 0.5
  always_comb begin
    if (e == 8'hFF && m != 23'd0) cls = CLS_NAN;
    else if (e >= 8'd128)         cls = s ? CLS_SAT0 : CLS_SAT1;
    else                          cls = CLS_LIN;
    scaled = (cls == CLS_LIN && e > 8'd2) ? {s, e - 8'd2, m} : 32'd0;
  end

  // index 0 is the input register; index ADD_LAT lines up with the adder output
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      vldPipe  <= '0;
      clsPipe  <= '0;
      s0Scaled <= '0;
    end else begin
      vldPipe  <= {vldPipe[ADD_LAT-1:0], iVALID};
      clsPipe  <= {clsPipe[ADD_LAT-1:0], cls};
      s0Scaled <= scaled;
    end
  end

  fp_add_sub #(.LAT(ADD_LAT)) uAdd (
    .clock  (iCLK),
    .add_sub(1'b1),
    .dataa  (s0Scaled),
    .datab  (32'h3F000000),
    .result (addRes)
  );

  always_comb begin
    case (clsPipe[ADD_LAT])
      CLS_SAT1: actN = 32'h3F800000;
      CLS_SAT0: actN = 32'h00000000;
      CLS_NAN:  actN = 32'h7FC00000;
      default:  actN = addRes[31] ? 32'h00000000 :
                       (addRes >= 32'h3F800000) ? 32'h3F800000 : addRes;
    endcase
    bitN = (clsPipe[ADD_LAT] != CLS_NAN) && (actN >= 32'h3F000000);
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oVALID <= 1'b0;
      oACT   <= 32'd0;
      oBIT   <= 1'b0;
      oCOUNT <= '0;
    end else if (vldPipe[ADD_LAT]) begin
      oVALID <= 1'b1;
      oACT   <= actN;
      oBIT   <= bitN;
      oCOUNT <= oCOUNT + 1'b1;
    end else begin
      oVALID <= 1'b0;
    end
  end
endmodule
